// File: rtl/game_pkg.sv
// Shared definitions for the reaction-game round controller.
//   - FSM state encoding (IDLE, GAP, ARM, RUN, DONE)
//   - round result codes reported on round_result
//   - nominal system clock frequency
package game_pkg;

   localparam int CLK_HZ = 100_000_000;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_GAP  = 3'd1;
   localparam logic [2:0] S_ARM  = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_HIT  = 2'b01,
      RES_MISS = 2'b10,
      RES_FOUL = 2'b11
   } result_t;

endpackage

// File: rtl/countdown_round_controller_rise_detect.sv
// Rising-edge detector used to turn the timer's level expiry flag into a
// single-cycle expire strobe.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   d     in  level input
//   rise  out high for the first cycle d is seen high after being low
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (reset) d_q <= 1'b0;
      else       d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/countdown_round_controller.sv
// Round sequencer for the reaction game built on the random countdown timer.
// Waits an idle gap, arms the timer, classifies the first player hit against
// the live count, reports the round result when the timer expires and stops
// after the last round (or when lives run out).
// Optional feature: define LIVES_EN to enable the lives counter; otherwise
// lives reads 0 and every game runs all NUM_ROUNDS rounds.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 1-cycle pulse, starts a game from IDLE/DONE
//   hit                   1-cycle pulse, player press
//   tmr_count             live timer count (0 when not counting)
//   tmr_gameover          timer expiry level
//   tmr_trigger           1-cycle arm pulse to the timer
//   round_num             current round (1-based, 0 after reset)
//   score                 successful rounds this game (saturating)
//   lives                 remaining lives
//   result_valid          1-cycle pulse when a round resolves
//   round_result          last round result code, held
//   busy                  high during GAP/ARM/RUN
//   game_over             high in DONE
module countdown_round_controller
   import game_pkg::*;
#(
   parameter int NUM_ROUNDS = 10,
   parameter int HIT_WINDOW = 2,
   parameter int GAP_CYCLES = 50_000_000,
   parameter int SCORE_W    = 4,
   parameter int MAX_LIVES  = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               hit,
   input  logic [4:0]         tmr_count,
   input  logic               tmr_gameover,
   output logic               tmr_trigger,
   output logic [3:0]         round_num,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         lives,
   output logic               result_valid,
   output logic [1:0]         round_result,
   output logic               busy,
   output logic               game_over
);

   localparam int                 GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
   localparam logic [4:0]         HIT_LIMIT  = 5'(HIT_WINDOW);
   localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
      $error("NUM_ROUNDS out of range");
   end
   if (GAP_CYCLES < 1) begin : g_bad_gap
      $error("GAP_CYCLES must be at least 1");
   end
   if (SCORE_W < $clog2(NUM_ROUNDS + 1)) begin : g_bad_score
      $error("SCORE_W too narrow for NUM_ROUNDS");
   end
   if (MAX_LIVES < 1 || MAX_LIVES > 3) begin : g_bad_lives
      $error("MAX_LIVES out of range");
   end

   logic [2:0]       state;
   logic [GAP_W-1:0] gap_cnt;
   logic             resolved;
   logic             expire;
   logic             hit_ok;
   logic             res_now;
   logic             out_of_lives;
   result_t          res_code;

   rise_detect u_expire (
      .clk   (clk),
      .reset (reset),
      .d     (tmr_gameover),
      .rise  (expire)
   );

   // A round resolves on the first hit, or on expiry if nothing hit first.
   // A hit landing in the expiry cycle is still classified as a hit.
   always_comb begin
      hit_ok  = (tmr_count <= HIT_LIMIT);
      res_now = (state == S_RUN) && !resolved && (hit || expire);
      if (hit) res_code = hit_ok ? RES_HIT : RES_FOUL;
      else     res_code = RES_MISS;
   end

`ifdef LIVES_EN
   logic [1:0] lives_q;
   logic [1:0] lives_nx;
   logic       penalty;

   always_comb begin
      penalty  = res_now && (res_code != RES_HIT);
      lives_nx = (penalty && lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
   end

   always_ff @(posedge clk) begin
      if (reset)
         lives_q <= 2'd0;
      else if ((state == S_IDLE || state == S_DONE) && start)
         lives_q <= 2'(MAX_LIVES);
      else
         lives_q <= lives_nx;
   end

   // Evaluated only at expiry; includes a penalty taken in that same cycle.
   assign out_of_lives = (lives_nx == 2'd0);
   assign lives        = lives_q;
`else
   assign out_of_lives = 1'b0;
   assign lives        = 2'd0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         gap_cnt      <= '0;
         resolved     <= 1'b0;
         round_num    <= 4'd0;
         score        <= '0;
         round_result <= RES_NONE;
         result_valid <= 1'b0;
      end else begin
         result_valid <= 1'b0;

         if (res_now) begin
            round_result <= res_code;
            resolved     <= 1'b1;
         end
         if (res_now && hit && hit_ok && score != SCORE_MAX)
            score <= score + SCORE_W'(1);

         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  round_num    <= 4'd1;
                  score        <= '0;
                  round_result <= RES_NONE;
                  gap_cnt      <= '0;
                  state        <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= S_ARM;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            S_ARM: begin
               resolved <= 1'b0;
               state    <= S_RUN;
            end
            S_RUN: begin
               if (expire) begin
                  result_valid <= 1'b1;
                  if (round_num == LAST_ROUND || out_of_lives) begin
                     state <= S_DONE;
                  end else begin
                     round_num <= round_num + 4'd1;
                     gap_cnt   <= '0;
                     state     <= S_GAP;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign tmr_trigger = (state == S_ARM);
   assign busy        = (state == S_GAP) || (state == S_ARM) || (state == S_RUN);
   assign game_over   = (state == S_DONE);

endmodule

// File: tb/tb_countdown_round_controller.sv
// Directed bench for countdown_round_controller with a behavioural timer:
// counts down from tm_start, one step per 10 clocks, counting begins two
// cycles after the trigger pulse, expiry flag held until the next trigger.
module tb_countdown_round_controller;
   import game_pkg::*;

   typedef struct {
      int mode;   // 0 no hit, 1 hit at c1, 2 hits at c1 then c2, 3 hit in expiry cycle
      int c1;
      int c2;
      int res;
      int score;
      int rnd;
      int go;
      int lives;
   } rnd_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       hit = 1'b0;
   logic [4:0] tmr_count = 5'd0;
   logic       tmr_gameover = 1'b0;
   logic       tmr_trigger;
   logic [3:0] round_num;
   logic [3:0] score;
   logic [1:0] lives;
   logic       result_valid;
   logic [1:0] round_result;
   logic       busy;
   logic       game_over;

   int n_chk = 0;
   int n_pass = 0;
   int tm_start = 6;
   int tm_sec = 0;
   logic tm_arm = 1'b0;

   rnd_t g1[3];
   rnd_t g2[3];
   int   n2;
   int   exp_lives_start;

   countdown_round_controller #(
      .NUM_ROUNDS (3),
      .HIT_WINDOW (2),
      .GAP_CYCLES (4),
      .SCORE_W    (4),
      .MAX_LIVES  (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .hit          (hit),
      .tmr_count    (tmr_count),
      .tmr_gameover (tmr_gameover),
      .tmr_trigger  (tmr_trigger),
      .round_num    (round_num),
      .score        (score),
      .lives        (lives),
      .result_valid (result_valid),
      .round_result (round_result),
      .busy         (busy),
      .game_over    (game_over)
   );

   always #5 clk = ~clk;

   // Behavioural countdown timer (no reset, like the real one).
   always @(posedge clk) begin
      if (tmr_trigger) begin
         tmr_gameover <= 1'b0;
         tm_arm       <= 1'b1;
         tmr_count    <= 5'd0;
      end else if (tm_arm) begin
         tm_arm    <= 1'b0;
         tmr_count <= 5'(tm_start);
         tm_sec    <= 0;
      end else if (tmr_count != 5'd0) begin
         if (tm_sec == 9) begin
            tm_sec <= 0;
            if (tmr_count == 5'd1) tmr_gameover <= 1'b1;
            tmr_count <= tmr_count - 5'd1;
         end else begin
            tm_sec <= tm_sec + 1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_hit();
      hit = 1'b1;
      tick();
      hit = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " tmr_trigger"},  int'(tmr_trigger), 0);
      chk({tag, " round_num"},    int'(round_num), 0);
      chk({tag, " score"},        int'(score), 0);
      chk({tag, " lives"},        int'(lives), 0);
      chk({tag, " result_valid"}, int'(result_valid), 0);
      chk({tag, " round_result"}, int'(round_result), 0);
      chk({tag, " busy"},         int'(busy), 0);
      chk({tag, " game_over"},    int'(game_over), 0);
   endtask

   task automatic wait_trig(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (tmr_trigger) begin
            tick();
            chk({tag, " trigger single cycle"}, int'(tmr_trigger), 0);
            return;
         end
         tick();
      end
      chk({tag, " trigger timeout"}, 0, 1);
   endtask

   task automatic wait_count(input int c, input string tag);
      for (int i = 0; i < 300; i++) begin
         if (int'(tmr_count) == c && !tmr_gameover) return;
         tick();
      end
      chk({tag, " count timeout"}, 0, 1);
   endtask

   task automatic wait_expiry(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (tmr_gameover) return;
         tick();
      end
      chk({tag, " expiry timeout"}, 0, 1);
   endtask

   task automatic play(input rnd_t r, input string tag);
      bit seen;
      wait_trig(tag);
      case (r.mode)
         1: begin wait_count(r.c1, tag); pulse_hit(); end
         2: begin
            wait_count(r.c1, tag); pulse_hit();
            wait_count(r.c2, tag); pulse_hit();
         end
         3: begin wait_expiry(tag); pulse_hit(); end
         default: ;
      endcase
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (result_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, " result_valid"}, int'(seen), 1);
      chk({tag, " round_result"}, int'(round_result), r.res);
      chk({tag, " score"},        int'(score), r.score);
      chk({tag, " round_num"},    int'(round_num), r.rnd);
      chk({tag, " game_over"},    int'(game_over), r.go);
      chk({tag, " lives"},        int'(lives), r.lives);
      tick();
      chk({tag, " result_valid pulse"}, int'(result_valid), 0);
      chk({tag, " round_result held"},  int'(round_result), r.res);
   endtask

   initial begin
      int gap;
      bit trig_seen;
      int trig_cnt;
      int busy_cnt;

`ifdef LIVES_EN
      exp_lives_start = 2;
      g1[0] = '{1, 1, 0, 1, 1, 2, 0, 2};
      g1[1] = '{2, 5, 1, 3, 1, 3, 0, 1};
      g1[2] = '{3, 0, 0, 1, 2, 3, 1, 1};
      g2[0] = '{0, 0, 0, 2, 0, 2, 0, 1};
      g2[1] = '{0, 0, 0, 2, 0, 2, 1, 0};
      g2[2] = '{0, 0, 0, 2, 0, 2, 1, 0};
      n2 = 2;
`else
      exp_lives_start = 0;
      g1[0] = '{1, 1, 0, 1, 1, 2, 0, 0};
      g1[1] = '{2, 5, 1, 3, 1, 3, 0, 0};
      g1[2] = '{3, 0, 0, 1, 2, 3, 1, 0};
      g2[0] = '{0, 0, 0, 2, 0, 2, 0, 0};
      g2[1] = '{0, 0, 0, 2, 0, 3, 0, 0};
      g2[2] = '{0, 0, 0, 2, 0, 3, 1, 0};
      n2 = 3;
`endif

      reset = 1'b1;
      repeat (3) tick();
      check_idle("reset");
      reset = 1'b0;
      tick();

      // Game 1: start, gap length, then hit / foul+ignored hit / hit at expiry
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start round_num", int'(round_num), 1);
      chk("start score", int'(score), 0);
      chk("start lives", int'(lives), exp_lives_start);
      chk("start busy", int'(busy), 1);
      gap = 0;
      trig_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (tmr_trigger) begin
            trig_seen = 1'b1;
            break;
         end
         if (busy) gap++;
         tick();
      end
      chk("gap trigger seen", int'(trig_seen), 1);
      chk("gap cycles", gap, 4);
      chk("trigger busy", int'(busy), 1);

      for (int k = 0; k < 3; k++) play(g1[k], $sformatf("g1r%0d", k + 1));
      chk("g1 end busy", int'(busy), 0);

      // Game 2: restart from DONE, no hits at all
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart round_num", int'(round_num), 1);
      chk("restart score", int'(score), 0);
      chk("restart game_over", int'(game_over), 0);
      chk("restart round_result", int'(round_result), 0);
      for (int k = 0; k < n2; k++) play(g2[k], $sformatf("g2r%0d", k + 1));

      // Reset in the middle of a running round
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_trig("g3");
      repeat (3) tick();
      chk("mid-run busy", int'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_idle("mid-run reset");
      trig_cnt = 0;
      busy_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (tmr_trigger) trig_cnt++;
         if (busy) busy_cnt++;
      end
      chk("post-reset trigger pulses", trig_cnt, 0);
      chk("post-reset busy cycles", busy_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
